// File: rtl/fc_mac_array_pkg.sv
// Shared definitions for the fully-connected MAC array: FSM encoding,
// width helpers and the output ReLU/saturation function.
package fc_mac_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_FINISH,
        ST_EMIT
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >>> 1;
        end
        return result;
    endfunction

    // Address/counter width that never collapses to zero bits.
    function automatic int width_of(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic logic signed [63:0] relu_sat(
        input logic signed [63:0] value,
        input int                 width,
        input bit                 relu_en
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        v     = (relu_en && (value < 0)) ? 64'sd0 : value;
        if (v > max_v) return max_v;
        if (v < min_v) return min_v;
        return v;
    endfunction

endpackage

// File: rtl/fc_mac_array_pe.sv
// One neuron lane: accumulates activation*weight products, then adds the
// bias, rescales to the Q format and applies ReLU/saturation.
module fc_pe
    import fc_mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 6,
    parameter int RELU_EN    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_clr,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    output logic signed [DATA_WIDTH-1:0] o_result
);

    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH:0]      w_sum;
    logic signed [ACC_WIDTH:0]      w_shifted;

    assign w_prod     = i_x * i_w;
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // NOTE: reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_clr ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    // Bias is aligned to the product scale (2*FRAC_BITS) before the final shift.
    assign w_sum     = (ACC_WIDTH+1)'(r_acc) + ((ACC_WIDTH+1)'(i_bias) <<< FRAC_BITS);
    assign w_shifted = w_sum >>> FRAC_BITS;
    assign o_result  = DATA_WIDTH'(relu_sat(64'(w_shifted), DATA_WIDTH, RELU_EN != 0));

endmodule

// File: rtl/fc_mac_array.sv
// Fully-connected layer engine: buffers one activation vector, then computes
// NUM_PE neurons per pass against streamed weights and emits results in order.
module fc_mac_array
    import fc_mac_array_pkg::*;
#(
    parameter int  DATA_WIDTH  = 12,
    parameter int  INPUT_SIZE  = 400,
    parameter int  OUTPUT_SIZE = 120,
    parameter int  NUM_PE      = 8,
    parameter int  ACC_WIDTH   = 32,
    parameter int  FRAC_BITS   = 6,
    parameter int  RELU_EN     = 1,
    localparam int W_AW        = width_of(INPUT_SIZE * OUTPUT_SIZE / NUM_PE),
    localparam int B_AW        = width_of(OUTPUT_SIZE / NUM_PE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         w_rd_en,
    output logic [W_AW-1:0]              w_addr,
    input  logic [NUM_PE*DATA_WIDTH-1:0] w_data,
    output logic [B_AW-1:0]              b_addr,
    input  logic [NUM_PE*DATA_WIDTH-1:0] b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int N_GROUPS = OUTPUT_SIZE / NUM_PE;
    localparam int IDX_W    = width_of(INPUT_SIZE);
    localparam int LANE_W   = width_of(NUM_PE);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(INPUT_SIZE - 1);
    localparam logic [B_AW-1:0]   LAST_GRP  = B_AW'(N_GROUPS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PE - 1);

    state_t                      r_state;
    logic [IDX_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            r_i;
    logic [B_AW-1:0]             r_g;
    logic [LANE_W-1:0]           r_lane;
    logic                        r_w_rd_en;
    logic [W_AW-1:0]             r_w_addr;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic signed [DATA_WIDTH-1:0] r_out_data;

    logic                        r_p0_valid;
    logic [IDX_W-1:0]            r_p0_idx;
    logic                        r_s1_valid;
    logic                        r_s1_first;
    logic signed [DATA_WIDTH-1:0] r_s1_x;
    logic signed [DATA_WIDTH-1:0] r_s1_w [NUM_PE];
    logic signed [DATA_WIDTH-1:0] r_buf  [INPUT_SIZE];

    logic signed [DATA_WIDTH-1:0] w_res [NUM_PE];
    logic                        w_in_fire;
    logic                        w_out_fire;
    logic [LANE_W-1:0]           w_next_lane;
    logic [W_AW-1:0]             w_next_base;

    assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_next_lane = r_lane + 1'b1;
    assign w_next_base = W_AW'((int'(r_g) + 1) * INPUT_SIZE);

    assign w_rd_en   = r_w_rd_en;
    assign w_addr    = r_w_addr;
    assign b_addr    = r_g;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // NOTE: the activation buffer is a plain memory with no reset; every entry
    // is rewritten by the next vector before it is read.
    always_ff @(posedge clk) begin
        if (w_in_fire) r_buf[r_cnt] <= in_data;
    end

    // p0 tracks the outstanding weight read; s1 holds the aligned operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p0_valid <= 1'b0;
            r_p0_idx   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_x     <= '0;
            for (int k = 0; k < NUM_PE; k++) r_s1_w[k] <= '0;
        end else begin
            r_p0_valid <= r_w_rd_en;
            r_p0_idx   <= r_i;
            r_s1_valid <= r_p0_valid;
            r_s1_first <= (r_p0_idx == '0);
            r_s1_x     <= r_buf[r_p0_idx];
            for (int k = 0; k < NUM_PE; k++) r_s1_w[k] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        fc_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .RELU_EN    (RELU_EN)
        ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (r_s1_valid),
            .i_clr    (r_s1_first),
            .i_x      (r_s1_x),
            .i_w      (r_s1_w[k]),
            .i_bias   (b_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_result (w_res[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_i         <= '0;
            r_g         <= '0;
            r_lane      <= '0;
            r_w_rd_en   <= 1'b0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state   <= ST_MAC;
                            r_cnt     <= '0;
                            r_i       <= '0;
                            r_g       <= '0;
                            r_w_rd_en <= 1'b1;
                            r_w_addr  <= '0;
                        end else begin
                            r_state <= ST_LOAD;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (r_i == LAST_IDX) begin
                        r_state   <= ST_FINISH;
                        r_w_rd_en <= 1'b0;
                    end else begin
                        r_i      <= r_i + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                end
                ST_FINISH: begin
                    // Accumulators are final once both pipeline stages are empty.
                    if (!r_p0_valid && !r_s1_valid) begin
                        r_state     <= ST_EMIT;
                        r_lane      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res[0];
                        r_out_last  <= (r_g == LAST_GRP) && (NUM_PE == 1);
                    end
                end
                ST_EMIT: begin
                    if (w_out_fire) begin
                        if (r_lane == LAST_LANE) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (r_g == LAST_GRP) begin
                                r_state <= ST_IDLE;
                                r_g     <= '0;
                            end else begin
                                r_state   <= ST_MAC;
                                r_g       <= r_g + 1'b1;
                                r_i       <= '0;
                                r_w_rd_en <= 1'b1;
                                r_w_addr  <= w_next_base;
                            end
                        end else begin
                            r_lane     <= w_next_lane;
                            r_out_data <= w_res[w_next_lane];
                            r_out_last <= (r_g == LAST_GRP) && (w_next_lane == LAST_LANE);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fc_mac_array.md
FC_MAC_ARRAY -- requirements
Module: fc_mac_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: signed fixed-point width of activations, weights, biases and outputs.
REQ-002 SHALL have parameter INPUT_SIZE, default 400: input vector length.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 120: output neuron count; SHALL be a multiple of NUM_PE.
REQ-004 SHALL have parameter NUM_PE, default 8: neurons computed in parallel.
REQ-005 SHALL have parameter ACC_WIDTH, default 32: accumulator width.
REQ-006 SHALL have parameter FRAC_BITS, default 6: fractional bits of the Q format.
REQ-007 SHALL have parameter RELU_EN, default 1: 1 clamps negative results to 0.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 in_valid / in_ready / in_data  in / out / DATA_WIDTH  activation stream, index 0 first.
REQ-011 w_rd_en / w_addr  out / out  1, clog2(INPUT_SIZE*OUTPUT_SIZE/NUM_PE)  weight read request.
REQ-012 w_data  in  NUM_PE*DATA_WIDTH  weights, valid exactly 1 cycle after w_rd_en; lane k = neuron g*NUM_PE+k.
REQ-013 b_addr  out  clog2(OUTPUT_SIZE/NUM_PE)  bias group; b_data  in  NUM_PE*DATA_WIDTH  valid 1 cycle after b_addr changes.
REQ-014 out_valid / out_ready / out_data / out_last  out / in / out / out  1, 1, DATA_WIDTH, 1  result stream, neuron 0 first.
REQ-015 busy  out  1  high in any state except IDLE.

Function
REQ-016 FSM states IDLE, LOAD, MAC, FINISH, EMIT; reset state IDLE.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD only; a handshake (in_valid & in_ready) writes in_data to buffer[cnt], cnt++.
REQ-018 First handshake in IDLE SHALL move to LOAD; handshake at cnt=INPUT_SIZE-1 SHALL move to MAC, group g=0, i=0.
REQ-019 MAC: w_rd_en=1, w_addr=g*INPUT_SIZE+i for i=0..INPUT_SIZE-1, one per cycle, no stalls.
REQ-020 Two-stage pipeline: stage 1 registers buffer[i] and w_data lanes; stage 2 acc[k] += buffer[i]*w[k] (full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH); acc cleared at i=0.
REQ-021 After last read, FINISH SHALL wait for pipeline drain (2 cycles), then result[k] = (acc[k] + (bias[k] <<< FRAC_BITS)) >>> FRAC_BITS (arithmetic).
REQ-022 Result SHALL be ReLU'd when RELU_EN=1, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 EMIT SHALL present NUM_PE results in lane order; out_data/out_valid held stable until out_ready; one beat per handshake.
REQ-024 out_last=1 only on neuron OUTPUT_SIZE-1.
REQ-025 After last beat of group g: g<OUTPUT_SIZE/NUM_PE-1 -> MAC with g+1; else -> IDLE.
REQ-026 Buffer SHALL be reused for all groups; no new input accepted until IDLE.
REQ-027 Latency per group without backpressure: INPUT_SIZE+3 cycles to first out_valid, then NUM_PE beats.
REQ-028 out_ready low SHALL stall only EMIT; MAC never stalls.

Reset
REQ-029 rst_n=0 at any edge, including mid-MAC/EMIT, SHALL force IDLE, cnt=i=g=0, acc=0, out_valid=0, out_last=0, out_data=0, w_rd_en=0, w_addr=0, b_addr=0, busy=0, in_ready=1 on the first cycle after release.
REQ-030 Partial input or results in flight at reset SHALL be discarded; buffer contents need not be cleared.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, clog2 function, saturate/ReLU helper.
REQ-032 One sub-module fc_pe (single lane: multiply, accumulate, bias, shift, ReLU, saturate) SHALL be instantiated NUM_PE times.

Verification (INPUT_SIZE=4, OUTPUT_SIZE=4, NUM_PE=2, DATA_WIDTH=12, FRAC_BITS=6)
REQ-033 x=1.0(64) all, weights 0.5(32), bias 0 -> four outputs 128 (2.0), out_last on 4th.
REQ-034 Weights -1.0, bias 0, RELU_EN=1 -> all outputs 0; RELU_EN=0 -> -256.
REQ-035 x=31.0, weights 31.0, bias 0 -> outputs saturate to 2047.
REQ-036 out_ready toggling 1/0 each cycle during EMIT -> same values, no drop or duplicate, out_data stable while stalled.
REQ-037 rst_n low 1 cycle during group-1 MAC -> IDLE, busy=0, out_valid=0; fresh vector then yields correct full result.
REQ-038 in_valid gaps during LOAD -> only handshaken beats stored; result identical to gapless run.
